// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: clear / shift / present sequencer for a SIPO chain.
// Counts N bit periods of DIV cycles, pulses the chain enable at the end
// of each period, then holds the frame under a valid/ready handshake.
// Optional feature macro: SIPO_FRAME_CTRL_PARITY_EN (even-parity bit check).
// Ports:
//   clk, rst (async, active-low)
//   start, abort                 frame request / cancel
//   serial_in                    serial line (also feeds the chain)
//   sr_clr, sr_en                chain clear and shift enable
//   busy, frame_valid            status and frame presentation
//   frame_ready                  consumer acceptance
//   bit_count                    data bits shifted so far
//   parity_err                   parity result (0 without the macro)
module sipo_frame_ctrl #(
    parameter int N   = 8,
    parameter int DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     serial_in,
    output logic                     sr_clr,
    output logic                     sr_en,
    output logic                     busy,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [$clog2(N+1)-1:0]   bit_count,
    output logic                     parity_err
);

    localparam int CW = $clog2(N + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] N_LAST   = CW'(N - 1);

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, CLEAR, SHIFT, PARITY, DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, CLEAR, SHIFT, DONE
    } state_t;
`endif

    state_t        state;
    logic [DW-1:0] div;
    logic          div_wrap;

    assign div_wrap = (div == DIV_LAST);

    // Outputs are pure decodes of registered state and the divider.
    assign sr_clr      = (state == CLEAR);
    assign sr_en       = (state == SHIFT) && div_wrap;
    assign frame_valid = (state == DONE);

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    assign busy = (state == CLEAR) || (state == SHIFT) ||
                  (state == PARITY);
`else
    assign busy = (state == CLEAR) || (state == SHIFT);
`endif

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    logic par;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            div        <= '0;
            bit_count  <= '0;
            par        <= 1'b0;
            parity_err <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            state      <= IDLE;
            parity_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state <= CLEAR;
                end
                CLEAR: begin
                    bit_count  <= '0;
                    div        <= '0;
                    par        <= 1'b0;
                    parity_err <= 1'b0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    div <= div_wrap ? '0 : div + 1'b1;
                    if (div_wrap) begin
                        bit_count <= bit_count + 1'b1;
                        par       <= par ^ serial_in;
                        if (bit_count == N_LAST) state <= PARITY;
                    end
                end
                PARITY: begin
                    // One more bit period; the chain is not shifted.
                    div <= div_wrap ? '0 : div + 1'b1;
                    if (div_wrap) begin
                        parity_err <= par ^ serial_in;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (frame_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // Serial data only reaches the chain; nothing here consumes it.
    logic unused_serial;
    assign unused_serial = serial_in;
    assign parity_err    = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            div       <= '0;
            bit_count <= '0;
        end else if (abort && (state != IDLE)) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state <= CLEAR;
                end
                CLEAR: begin
                    bit_count <= '0;
                    div       <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    div <= div_wrap ? '0 : div + 1'b1;
                    if (div_wrap) begin
                        bit_count <= bit_count + 1'b1;
                        if (bit_count == N_LAST) state <= DONE;
                    end
                end
                DONE: begin
                    if (frame_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: randomized frames checked against a cycle schedule
// derived from the frame timing rules, plus abort and async reset cases.
module tb_sipo_frame_ctrl;

    localparam int N = 8;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic serial_in = 1'b0;
    logic frame_ready = 1'b0;

    logic       sr_clr0, sr_en0, busy0, fv0, pe0;
    logic [3:0] bc0;
    logic       sr_clr1, sr_en1, busy1, fv1, pe1;
    logic [3:0] bc1;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.N(N), .DIV(4)) u_div4 (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .serial_in   (serial_in),
        .sr_clr      (sr_clr0),
        .sr_en       (sr_en0),
        .busy        (busy0),
        .frame_valid (fv0),
        .frame_ready (frame_ready),
        .bit_count   (bc0),
        .parity_err  (pe0)
    );

    sipo_frame_ctrl #(.N(N), .DIV(1)) u_div1 (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .serial_in   (serial_in),
        .sr_clr      (sr_clr1),
        .sr_en       (sr_en1),
        .busy        (busy1),
        .frame_valid (fv1),
        .frame_ready (frame_ready),
        .bit_count   (bc1),
        .parity_err  (pe1)
    );

    int cur_div = 4;

    wire       m_clr = (cur_div == 1) ? sr_clr1 : sr_clr0;
    wire       m_en  = (cur_div == 1) ? sr_en1  : sr_en0;
    wire       m_bsy = (cur_div == 1) ? busy1   : busy0;
    wire       m_fv  = (cur_div == 1) ? fv1     : fv0;
    wire       m_pe  = (cur_div == 1) ? pe1     : pe0;
    wire [3:0] m_bc  = (cur_div == 1) ? bc1     : bc0;

    // Behavioural shift-register chain fed by the controller.
    logic [7:0] chain = '0;
    always @(posedge clk) begin
        if (m_clr)     chain <= '0;
        else if (m_en) chain <= {chain[6:0], serial_in};
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered in cycle 0 (after an edge, DUT idle); start is raised here.
    // Returns in the IDLE cycle that follows the handshake.
    task automatic run_frame(input int div, input logic [7:0] data,
                             input bit pbit, input int hold,
                             input bit noise);
        int fv, last, cnt, k;
        bit perr, exp_en;
        cur_div = div;
        fv   = 2 + (N + PAR) * div;
        last = fv + hold + 1;
        perr = (PAR == 1) ? ((^data) ^ pbit) : 1'b0;
        start = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            start = (noise && c >= 2 && c < last) ?
                    1'($urandom_range(0, 1)) : 1'b0;
            frame_ready = (c == fv + hold);
            serial_in = 1'($urandom_range(0, 1));
            exp_en = (c > 1) && ((c - 1) % div == 0) &&
                     (c <= 1 + N * div);
            if (exp_en) begin
                k = (c - 1) / div;
                serial_in = data[N - k];
            end
            if (PAR == 1 && c == 1 + (N + 1) * div) serial_in = pbit;
            @(negedge clk);
            chk($sformatf("sr_clr d%0d c%0d", div, c), m_clr, c == 1);
            chk($sformatf("sr_en d%0d c%0d", div, c), m_en, exp_en);
            chk($sformatf("valid d%0d c%0d", div, c), m_fv,
                (c >= fv) && (c < last));
            chk($sformatf("busy d%0d c%0d", div, c), m_bsy, c < fv);
            if (c >= 2) begin
                cnt = (c - 2) / div;
                if (cnt > N) cnt = N;
                chk($sformatf("bit_count d%0d c%0d", div, c), m_bc, cnt);
                chk($sformatf("parity_err d%0d c%0d", div, c), m_pe,
                    (c >= fv) ? perr : 1'b0);
            end
        end
        chk($sformatf("chain d%0d", div), chain, data);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int cnt;
        bit exp_en;
        #12;
        chk("rst sr_clr", sr_clr0, 0);
        chk("rst sr_en", sr_en0, 0);
        chk("rst busy", busy0, 0);
        chk("rst valid", fv0, 0);
        chk("rst bit_count", bc0, 0);
        chk("rst parity_err", pe0, 0);
        chk("rst valid1", fv1, 0);
        chk("rst busy1", busy1, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic frame with a 10-cycle ready hold, then back-to-back frames.
        run_frame(4, 8'hA5, 1'b0, 10, 1'b0);
        for (int i = 0; i < 3; i++)
            run_frame(4, 8'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 12), 1'b1);
        run_frame(4, 8'h07, 1'b1, 2, 1'b0);
        run_frame(4, 8'h07, 1'b0, 2, 1'b0);

        // Abort after the 3rd enable, with start high in the same cycle.
        cur_div = 4;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            start = (c == 14);
            abort = (c == 14);
            serial_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c <= 14) begin
                exp_en = (c > 1) && ((c - 1) % 4 == 0);
                chk($sformatf("abt sr_en c%0d", c), sr_en0, exp_en);
                chk($sformatf("abt busy c%0d", c), busy0, 1);
            end else begin
                chk($sformatf("abt busy c%0d", c), busy0, 0);
                chk($sformatf("abt valid c%0d", c), fv0, 0);
                chk($sformatf("abt sr_clr c%0d", c), sr_clr0, 0);
                chk($sformatf("abt sr_en c%0d", c), sr_en0, 0);
                chk($sformatf("abt perr c%0d", c), pe0, 0);
            end
        end
        abort = 1'b0;
        frame_ready = 1'b0;

        // Asynchronous reset mid-SHIFT, between clock edges.
        reset_pulse();
        cur_div = 4;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            serial_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("pre-rst busy", busy0, 1);
        chk("pre-rst bit_count", bc0, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst busy", busy0, 0);
        chk("arst sr_en", sr_en0, 0);
        chk("arst sr_clr", sr_clr0, 0);
        chk("arst valid", fv0, 0);
        chk("arst bit_count", bc0, 0);
        chk("arst parity_err", pe0, 0);
        @(posedge clk);
        #1;
        chk("arst hold busy", busy0, 0);
        rst = 1'b1;
        run_frame(4, 8'($urandom), 1'($urandom_range(0, 1)), 1, 1'b0);

        // DIV=1 instance, with start noise during SHIFT.
        reset_pulse();
        for (int i = 0; i < 3; i++)
            run_frame(1, 8'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), 1'b1);

        cnt = n_chk;
        if (cnt == 0) n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
